// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: start-bit detect, WIDTH-bit MSB-first capture, stop-bit check and
// valid/ready word hand-off. Define SIPO_RX_PARITY_EN for an even-parity bit after the data.
module sipo_rx_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frm_err,
  output logic             par_err,
  output logic             overrun
);
  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t           state, state_d;
  logic [WIDTH-1:0] sr, sr_d, dout_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             stop_eval, good, load;
  logic             valid_d, busy_d, frm_d, ovr_d;
  logic             par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (bit_en) begin
      case (state)
        IDLE: if (!din) state_d = DATA;
`ifdef SIPO_RX_PARITY_EN
        DATA:   if (cnt == LAST) state_d = PARITY;
        PARITY: state_d = STOP;
`else
        DATA:   if (cnt == LAST) state_d = STOP;
`endif
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sr_d      = sr;
    cnt_d     = cnt;
    stop_eval = bit_en && (state == STOP);
    good      = stop_eval && din && !par_bad;
    load      = good && (!dout_valid || dout_ready);
    frm_d     = stop_eval && !din;
    ovr_d     = good && dout_valid && !dout_ready;
    dout_d    = load ? sr : dout;
    valid_d   = load ? 1'b1 : (dout_valid && !dout_ready);
    // busy also covers the cycle after the stop sample, alongside the result outputs
    busy_d    = (state_d != IDLE) || stop_eval;
    if (bit_en && (state == IDLE) && !din) cnt_d = '0;
    if (bit_en && (state == DATA)) begin
      sr_d  = {sr[WIDTH-2:0], din};
      cnt_d = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      frm_err    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sr         <= sr_d;
      cnt        <= cnt_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      busy       <= busy_d;
      frm_err    <= frm_d;
      overrun    <= ovr_d;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  logic par_bad_d, par_d;

  always_comb begin
    par_bad_d = par_bad;
    if (bit_en && (state == IDLE) && !din) par_bad_d = 1'b0;
    if (bit_en && (state == PARITY))       par_bad_d = ((^sr) != din);
    par_d = stop_eval && din && par_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad <= 1'b0;
      par_err <= 1'b0;
    end else begin
      par_bad <= par_bad_d;
      par_err <= par_d;
    end
  end
`else
  assign par_bad = 1'b0;
  assign par_err = 1'b0;
`endif

endmodule
